// File: rtl/fp_pkg.sv
// Shared definitions for the custom sign/exponent/mantissa float datapath blocks.
// Latency: n/a (types, defaults and constant functions only).
// Backpressure: n/a.
// Contents: default field widths, exponent bias function, result flag encoding.
package fp_pkg;

  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 8;

  // Exponent bias for an EXP_W-bit biased exponent field.
  function automatic int fp_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

  // Result status; overflow and underflow are mutually exclusive by construction.
  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_OVF  = 2'b01,
    FLAG_UNF  = 2'b10
  } fp_flag_e;

endpackage

// File: rtl/fp_norm_round.sv
// Normalise, round, saturate/flush a raw float product into {sign, exp, man}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the result under its own enable.
// Ports: sign/zero/e (signed EXP_W+2 unbiased-sum exponent)/p (2*MAN_W+2 bit
//   product of the two hidden-1 mantissas) in; res (packed float) and flag out.
// Build option: FP_MULT_ROUND_EN selects round-to-nearest-even, otherwise truncation.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int FP_W = 1 + EXP_W + MAN_W,
  localparam int EW2  = EXP_W + 2,
  localparam int PW   = 2 * MAN_W + 2
) (
  input  logic             sign,
  input  logic             zero,
  input  logic [EW2-1:0]   e,
  input  logic [PW-1:0]    p,
  output logic [FP_W-1:0]  res,
  output fp_flag_e         flag
);

`ifdef FP_MULT_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic signed [EW2-1:0] E_MAX = EW2'(2 ** EXP_W - 1);
  localparam logic signed [EW2-1:0] E_MIN = EW2'(1);

  logic [PW-2:0]         norm;
  logic [MAN_W-1:0]      mant;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [MAN_W:0]        mant_sum;
  logic signed [EW2-1:0] e_n;
  logic signed [EW2-1:0] e_r;
  logic                  ovf;
  logic                  unf;

  // Product of two [1,2) values lies in [1,4). Align so the leading one sits
  // just above norm, dropping it; the shifted-out LSB stays in the sticky range.
  assign norm     = p[PW-1] ? p[PW-2:0] : {p[PW-3:0], 1'b0};
  assign mant     = norm[PW-2 -: MAN_W];
  assign guard    = norm[MAN_W];
  assign sticky   = |norm[MAN_W-1:0];
  assign round_up = ROUND_EN & guard & (sticky | mant[0]);

  // A carry out of the mantissa leaves it all-zero and bumps the exponent.
  assign mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
  assign e_n      = e + {{(EW2-1){1'b0}}, p[PW-1]};
  assign e_r      = e_n + {{(EW2-1){1'b0}}, mant_sum[MAN_W]};

  assign ovf = (e_r > E_MAX);
  assign unf = (e_r < E_MIN);

  // Zero operand wins over any exponent range condition.
  always_comb begin
    res  = {sign, e_r[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    flag = FLAG_NONE;
    if (zero) begin
      res = {sign, {(FP_W-1){1'b0}}};
    end else if (ovf) begin
      res  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      flag = FLAG_OVF;
    end else if (unf) begin
      res  = {sign, {(FP_W-1){1'b0}}};
      flag = FLAG_UNF;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined multiplier for custom {sign, exp, man} floats, one op per cycle.
// Latency: 3 cycles from input accept to o_valid (S1 exponent/sign, S2 mantissa product, S3 normalise/round).
// Backpressure: single global enable; when o_valid && !i_ready every stage and output holds and o_ready drops.
// Ports: clock, i_reset (sync, active-high); i_valid/o_ready/i_flotante_1/i_flotante_2 operand side;
//   o_valid/i_ready/o_producto/o_overflow/o_underflow result side (flags qualified by o_valid).
// Build option: FP_MULT_ROUND_EN enables round-to-nearest-even in fp_norm_round (truncation otherwise).
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [FP_W-1:0] i_flotante_1,
  input  logic [FP_W-1:0] i_flotante_2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [FP_W-1:0] o_producto,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic [EW2-1:0] BIAS_E = EW2'(BIAS);

  logic adv;

  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [EW2-1:0]   e_sum;

  logic             s1_vld;
  logic             s1_sign;
  logic             s1_zero;
  logic [EW2-1:0]   s1_e;
  logic [MAN_W-1:0] s1_man_a;
  logic [MAN_W-1:0] s1_man_b;

  logic [PW-1:0]    mul_a;
  logic [PW-1:0]    mul_b;

  logic             s2_vld;
  logic             s2_sign;
  logic             s2_zero;
  logic [EW2-1:0]   s2_e;
  logic [PW-1:0]    s2_p;

  logic [FP_W-1:0]  nr_res;
  fp_flag_e         nr_flag;

  // The whole pipe moves together: it may advance whenever the output
  // register is empty or being drained this cycle.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  assign exp_a = i_flotante_1[FP_W-2 -: EXP_W];
  assign exp_b = i_flotante_2[FP_W-2 -: EXP_W];
  // Two extra bits hold both the carry of the sum and a negative result.
  assign e_sum = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_E;

  assign mul_a = {{(MAN_W+1){1'b0}}, 1'b1, s1_man_a};
  assign mul_b = {{(MAN_W+1){1'b0}}, 1'b1, s1_man_b};

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .sign (s2_sign),
    .zero (s2_zero),
    .e    (s2_e),
    .p    (s2_p),
    .res  (nr_res),
    .flag (nr_flag)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      o_valid     <= 1'b0;
      o_producto  <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (adv) begin
      s1_vld   <= i_valid;
      s1_sign  <= i_flotante_1[FP_W-1] ^ i_flotante_2[FP_W-1];
      s1_zero  <= (exp_a == '0) | (exp_b == '0);
      s1_e     <= e_sum;
      s1_man_a <= i_flotante_1[MAN_W-1:0];
      s1_man_b <= i_flotante_2[MAN_W-1:0];

      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_e    <= s1_e;
      s2_p    <= mul_a * mul_b;

      o_valid <= s2_vld;
      // Bubbles leave the last result in place rather than loading junk.
      if (s2_vld) begin
        o_producto  <= nr_res;
        o_overflow  <= (nr_flag == FLAG_OVF);
        o_underflow <= (nr_flag == FLAG_UNF);
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
module tb_fp_mult_pipe;

  localparam int FP_W = 13;

  logic            clock = 1'b0;
  logic            i_reset;
  logic            i_valid;
  logic            o_ready;
  logic [FP_W-1:0] i_flotante_1;
  logic [FP_W-1:0] i_flotante_2;
  logic            o_valid;
  logic            i_ready;
  logic [FP_W-1:0] o_producto;
  logic            o_overflow;
  logic            o_underflow;

  always #5 clock = ~clock;

  fp_mult_pipe #(
    .EXP_W (4),
    .MAN_W (8)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flotante_1 (i_flotante_1),
    .i_flotante_2 (i_flotante_2),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_producto   (o_producto),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [FP_W-1:0] prod;
    logic            ovf;
    logic            unf;
  } vec_t;

  typedef struct packed {
    logic [FP_W-1:0] prod;
    logic            ovf;
    logic            unf;
    logic [31:0]     cyc;
    logic            chk_lat;
  } exp_t;

`ifdef FP_MULT_ROUND_EN
  localparam logic [FP_W-1:0] V3_PROD = 13'b0_1001_00000001;
  localparam logic [FP_W-1:0] V7_PROD = 13'b0_1000_00000000;
`else
  localparam logic [FP_W-1:0] V3_PROD = 13'b0_1001_00000000;
  localparam logic [FP_W-1:0] V7_PROD = 13'b0_0111_11111111;
`endif

  vec_t vecs [11];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_cmp = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input vec_t v, input logic lat);
    int w;
    exp_t item;
    i_valid      = 1'b1;
    i_flotante_1 = v.a;
    i_flotante_2 = v.b;
    w = 0;
    @(negedge clock);
    while (!o_ready && w < 100) begin
      w++;
      @(negedge clock);
    end
    if (!o_ready) begin
      check("accept_timeout", 32'(o_ready), 32'd1);
    end else begin
      item.prod    = v.prod;
      item.ovf     = v.ovf;
      item.unf     = v.unf;
      item.cyc     = 32'(cyc);
      item.chk_lat = lat;
      sb_q.push_back(item);
      n_vec++;
    end
    @(posedge clock);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(posedge clock);
      w++;
    end
    #1;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: pops on each output transfer, checks hold behaviour during stalls.
  always @(negedge clock) begin
    exp_t item;
    if (!i_reset && o_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 32'(o_valid), 32'd0);
      end else if (i_ready) begin
        item = sb_q.pop_front();
        check("producto", 32'(o_producto), 32'(item.prod));
        check("overflow", 32'(o_overflow), 32'(item.ovf));
        check("underflow", 32'(o_underflow), 32'(item.unf));
        if (item.chk_lat)
          check("latency", 32'(cyc) - item.cyc, 32'd3);
      end else begin
        check("stall_producto", 32'(o_producto), 32'(sb_q[0].prod));
        check("stall_ready", 32'(o_ready), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{13'b1_0101_11000110, 13'b0_1100_00011101, 13'b1_1010_11111001, 1'b0, 1'b0};
    vecs[1]  = '{13'b0_0011_11001101, 13'b1_1011_00101011, 13'b1_1000_00001101, 1'b0, 1'b0};
    vecs[2]  = '{13'b0_1100_00011101, 13'b0_0011_11001101, V3_PROD,             1'b0, 1'b0};
    vecs[3]  = '{13'b0_1100_00011101, 13'b0_1100_00011101, 13'b0_1111_11111111, 1'b1, 1'b0};
    vecs[4]  = '{13'b0_0001_00000000, 13'b0_0001_00000000, 13'b0_0000_00000000, 1'b0, 1'b1};
    vecs[5]  = '{13'b1_0000_00000000, 13'b0_1011_00101011, 13'b1_0000_00000000, 1'b0, 1'b0};
    // 1.4140625^2: rounding carries out of the mantissa into the exponent
    vecs[6]  = '{13'b0_0111_01101010, 13'b0_0111_01101010, V7_PROD,             1'b0, 1'b0};
    // largest exponent without overflow, smallest without underflow
    vecs[7]  = '{13'b0_1011_00000000, 13'b0_1011_00000000, 13'b0_1111_00000000, 1'b0, 1'b0};
    vecs[8]  = '{13'b1_0100_00000000, 13'b1_0100_00000000, 13'b0_0001_00000000, 1'b0, 1'b0};
    // exponent lands on 0 -> flush
    vecs[9]  = '{13'b0_0100_00000000, 13'b1_0011_00000000, 13'b1_0000_00000000, 1'b0, 1'b1};
    // zero operand suppresses the underflow the exponents alone would give
    vecs[10] = '{13'b0_0000_00000000, 13'b1_0001_00000000, 13'b1_0000_00000000, 1'b0, 1'b0};

    i_reset      = 1'b1;
    i_valid      = 1'b0;
    i_ready      = 1'b1;
    i_flotante_1 = '0;
    i_flotante_2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_producto", 32'(o_producto), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_underflow", 32'(o_underflow), 32'd0);
    i_reset = 1'b0;
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    @(posedge clock);
    #1;

    // Isolated directed vectors, latency checked on each.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i], 1'b1);
      drain();
    end

    // Back-to-back stream with a 5-cycle downstream stall in the middle.
    fork
      begin
        issue(vecs[0], 1'b0);
        issue(vecs[1], 1'b0);
        issue(vecs[3], 1'b0);
        issue(vecs[5], 1'b0);
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        i_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: nothing may emerge afterwards.
    issue(vecs[0], 1'b0);
    issue(vecs[1], 1'b0);
    issue(vecs[2], 1'b0);
    i_reset = 1'b1;
    sb_q.delete();
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    check("reset_flush_valid", 32'(o_valid), 32'd0);
    repeat (8) @(posedge clock);
    #1;

    issue(vecs[6], 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
